// File: rtl/gpio_in_debounce_irq.sv
// Pad input conditioning: per-bit synchroniser, debounce filter, edge-to-status capture with W1C clear and one level irq.
// Pad step reaches gpio_in_sync after SYNC_STAGES+DEBOUNCE_CYCLES cycles; the register slave has no backpressure.
module gpio_in_debounce_irq #(
  parameter int WIDTH           = 32,
  parameter int SYNC_STAGES     = 2,
  parameter int DEBOUNCE_CYCLES = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] pad_in,
  input  logic             we,
  input  logic             re,
  input  logic [3:0]       addr,
  input  logic [31:0]      wdata,
  output logic [31:0]      rdata,
  output logic [WIDTH-1:0] gpio_in_sync,
  output logic             irq
);

  localparam int             CW      = $clog2(DEBOUNCE_CYCLES) + 1;
  localparam logic [CW-1:0]  CNT_MAX = CW'(DEBOUNCE_CYCLES - 1);

  localparam logic [3:0] A_RISE_EN = 4'h0;
  localparam logic [3:0] A_FALL_EN = 4'h4;
  localparam logic [3:0] A_STATUS  = 4'h8;
  localparam logic [3:0] A_LEVEL   = 4'hC;

  logic [WIDTH-1:0] r_sync [SYNC_STAGES];
  logic [WIDTH-1:0] r_stable;
  logic [WIDTH-1:0] r_rise_en;
  logic [WIDTH-1:0] r_fall_en;
  logic [WIDTH-1:0] r_status;
  logic             r_irq;

  logic [WIDTH-1:0] w_s;
  logic [WIDTH-1:0] w_diff;
  logic [WIDTH-1:0] w_tog;
  logic [WIDTH-1:0] w_set_r;
  logic [WIDTH-1:0] w_set_f;
  logic [WIDTH-1:0] w_clr;
  logic             w_wr_rise;
  logic             w_wr_fall;
  logic             w_wr_status;

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int k = 0; k < SYNC_STAGES; k++) r_sync[k] <= '0;
    end else begin
      r_sync[0] <= pad_in;
      for (int k = 1; k < SYNC_STAGES; k++) r_sync[k] <= r_sync[k-1];
    end
  end

  assign w_s    = r_sync[SYNC_STAGES-1];
  assign w_diff = w_s ^ r_stable;

  // The counter runs only while the synchronised level disagrees with the accepted one,
  // so any agreeing sample throws away the partial count.
  for (genvar i = 0; i < WIDTH; i++) begin : g_db
    logic [CW-1:0] r_cnt;

    assign w_tog[i] = w_diff[i] && (r_cnt == CNT_MAX);

    always_ff @(posedge clk) begin
      if (reset || !w_diff[i] || w_tog[i]) begin
        r_cnt <= '0;
      end else begin
        r_cnt <= r_cnt + CW'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_stable <= '0;
    end else begin
      r_stable <= r_stable ^ w_tog;
    end
  end

  assign gpio_in_sync = r_stable;

  assign w_wr_rise   = we && (addr == A_RISE_EN);
  assign w_wr_fall   = we && (addr == A_FALL_EN);
  assign w_wr_status = we && (addr == A_STATUS);

  assign w_set_r = w_tog & ~r_stable & r_rise_en;
  assign w_set_f = w_tog &  r_stable & r_fall_en;
  assign w_clr   = w_wr_status ? wdata[WIDTH-1:0] : '0;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_rise_en <= '0;
      r_fall_en <= '0;
    end else begin
      if (w_wr_rise) r_rise_en <= wdata[WIDTH-1:0];
      if (w_wr_fall) r_fall_en <= wdata[WIDTH-1:0];
    end
  end

  // A new edge outranks a same-cycle W1C clear of that bit.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_status <= '0;
      r_irq    <= 1'b0;
    end else begin
      r_status <= (r_status & ~w_clr) | w_set_r | w_set_f;
      r_irq    <= |r_status;
    end
  end

  assign irq = r_irq;

  always_comb begin
    rdata = '0;
    if (re) begin
      case (addr)
        A_RISE_EN: rdata[WIDTH-1:0] = r_rise_en;
        A_FALL_EN: rdata[WIDTH-1:0] = r_fall_en;
        A_STATUS:  rdata[WIDTH-1:0] = r_status;
        A_LEVEL:   rdata[WIDTH-1:0] = r_stable;
        default:   rdata = '0;
      endcase
    end
  end

endmodule

// File: tb/tb_gpio_in_debounce_irq.sv
// Directed bench for gpio_in_debounce_irq with a cycle-by-cycle window-based reference model.
module tb_gpio_in_debounce_irq;

  localparam int W  = 32;
  localparam int SS = 2;
  localparam int D  = 16;

  logic          clk;
  logic          reset;
  logic [W-1:0]  pad_in;
  logic          we;
  logic          re;
  logic [3:0]    addr;
  logic [31:0]   wdata;
  logic [31:0]   rdata;
  logic [W-1:0]  gpio_in_sync;
  logic          irq;

  gpio_in_debounce_irq #(
    .WIDTH(W), .SYNC_STAGES(SS), .DEBOUNCE_CYCLES(D)
  ) dut (
    .clk(clk), .reset(reset), .pad_in(pad_in), .we(we), .re(re),
    .addr(addr), .wdata(wdata), .rdata(rdata),
    .gpio_in_sync(gpio_in_sync), .irq(irq)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;
  bit chk_en = 1'b0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Reference model: a level is accepted once the last D synchronised samples
  // (pad delayed SS edges) all disagree with the currently accepted level.
  logic [31:0] p_hist[$];
  logic [31:0] m_stable, m_rise, m_fall, m_status;
  logic        m_irq;
  logic [31:0] md_all, md_s, md_set, md_clr;
  int          md_m, md_idx;

  always @(posedge clk) begin
    if (reset) begin
      p_hist.delete();
      m_stable = '0; m_rise = '0; m_fall = '0; m_status = '0; m_irq = 1'b0;
    end else begin
      md_m   = p_hist.size() + 1;
      md_all = '1;
      for (int k = 0; k < D; k++) begin
        md_idx = md_m - SS - k;
        md_s   = (md_idx >= 1) ? p_hist[md_idx-1] : 32'h0;
        md_all = md_all & (md_s ^ m_stable);
      end
      md_set   = (md_all & ~m_stable & m_rise) | (md_all & m_stable & m_fall);
      md_clr   = (we && addr == 4'h8) ? wdata : 32'h0;
      m_irq    = |m_status;
      m_status = (m_status & ~md_clr) | md_set;
      if (we && addr == 4'h0) m_rise = wdata;
      if (we && addr == 4'h4) m_fall = wdata;
      m_stable = m_stable ^ md_all;
      p_hist.push_back(pad_in);
    end
  end

  function automatic logic [31:0] m_read(input logic r, input logic [3:0] a);
    if (!r) return 32'h0;
    case (a)
      4'h0:    return m_rise;
      4'h4:    return m_fall;
      4'h8:    return m_status;
      4'hC:    return m_stable;
      default: return 32'h0;
    endcase
  endfunction

  always @(negedge clk) begin
    if (chk_en) begin
      chk("cyc_gpio_in_sync", gpio_in_sync, m_stable);
      chk("cyc_irq", {31'b0, irq}, {31'b0, m_irq});
      chk("cyc_rdata", rdata, m_read(re, addr));
    end
  end

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic steps(input int n);
    for (int k = 0; k < n; k++) step();
  endtask

  task automatic wr(input logic [3:0] a, input logic [31:0] d);
    we = 1'b1; addr = a; wdata = d;
    step();
    we = 1'b0; wdata = '0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1; pad_in = 32'hFFFF_FFFF; we = 1'b0; re = 1'b1; addr = 4'h8; wdata = '0;

    // 1. pad held high through reset
    steps(3);
    chk_en = 1'b1;
    chk("rst_gpio", gpio_in_sync, 32'h0);
    chk("rst_irq", {31'b0, irq}, 32'h0);
    chk("rst_status", rdata, 32'h0);
    reset = 1'b0;
    for (int k = 1; k <= 18; k++) begin
      step();
      chk($sformatf("t1_gpio_c%0d", k), gpio_in_sync, (k >= 18) ? 32'hFFFF_FFFF : 32'h0);
    end
    step();
    chk("t1_status", rdata, 32'h0);
    chk("t1_irq", {31'b0, irq}, 32'h0);

    // 2. rise on bit 0 with RISE_EN[0]
    pad_in = 32'h0;
    steps(20);
    wr(4'h0, 32'h1);
    addr = 4'h8; pad_in = 32'h1;
    for (int k = 1; k <= 19; k++) begin
      step();
      if (k == 17) chk("t2_status_c17", rdata, 32'h0);
      if (k == 18) begin
        chk("t2_status_c18", rdata, 32'h1);
        chk("t2_irq_c18", {31'b0, irq}, 32'h0);
      end
      if (k == 19) chk("t2_irq_c19", {31'b0, irq}, 32'h1);
    end
    addr = 4'hC; #1;
    chk("t2_level", rdata, 32'h1);

    // 4. W1C clear, irq drops one cycle later
    wr(4'h8, 32'h1);
    addr = 4'h8; #1;
    chk("t4_status", rdata, 32'h0);
    chk("t4_irq_same", {31'b0, irq}, 32'h1);
    step();
    chk("t4_irq_next", {31'b0, irq}, 32'h0);

    // 3. 10-cycle glitch is rejected
    pad_in = 32'h0;
    steps(20);
    pad_in = 32'h1;
    steps(10);
    pad_in = 32'h0;
    for (int k = 0; k < 25; k++) begin
      step();
      chk("t3_gpio0", {31'b0, gpio_in_sync[0]}, 32'h0);
    end
    chk("t3_status", rdata, 32'h0);
    chk("t3_irq", {31'b0, irq}, 32'h0);

    // 4a. rise lands on the same edge as a W1C of that bit
    pad_in = 32'h1;
    steps(17);
    we = 1'b1; addr = 4'h8; wdata = 32'h1;
    step();
    we = 1'b0; wdata = '0; #1;
    chk("t4a_status", rdata, 32'h1);
    step();
    chk("t4a_irq", {31'b0, irq}, 32'h1);
    wr(4'h8, 32'h1);
    addr = 4'h8; #1;
    chk("t4a_cleared", rdata, 32'h0);

    // 5. fall on bit 31 with FALL_EN[31]
    wr(4'h4, 32'h8000_0000);
    pad_in = 32'h8000_0000;
    steps(20);
    wr(4'h8, 32'hFFFF_FFFF);
    addr = 4'h8; pad_in = 32'h0;
    for (int k = 1; k <= 18; k++) begin
      step();
      if (k == 17) chk("t5_status_c17", rdata, 32'h0);
      if (k == 18) chk("t5_status_c18", rdata, 32'h8000_0000);
    end
    step();
    wr(4'h8, 32'hFFFF_FFFF);

    // 5a. register readback and re gating
    wr(4'h0, 32'hA5);
    addr = 4'h0; re = 1'b1; #1;
    chk("t5a_re1", rdata, 32'hA5);
    re = 1'b0; #1;
    chk("t5a_re0", rdata, 32'h0);
    re = 1'b1;
    step();
    addr = 4'h4; #1;
    chk("t5a_fall_en", rdata, 32'h8000_0000);
    wr(4'h2, 32'hFFFF_FFFF);
    addr = 4'h2; #1;
    chk("t5a_unlisted", rdata, 32'h0);
    wr(4'hC, 32'h1234_5678);
    addr = 4'hC; #1;
    chk("t5a_level_ro", rdata, 32'h0);

    // 6. reset mid-debounce restarts the full latency
    addr = 4'h8;
    pad_in = 32'hF;
    steps(5);
    reset = 1'b1;
    step();
    chk("t6_rst_gpio", gpio_in_sync, 32'h0);
    reset = 1'b0;
    for (int k = 1; k <= 18; k++) begin
      step();
      chk($sformatf("t6_gpio_c%0d", k), gpio_in_sync, (k >= 18) ? 32'hF : 32'h0);
    end
    step();
    chk("t6_status", rdata, 32'h0);
    chk("t6_irq", {31'b0, irq}, 32'h0);

    steps(2);
    chk_en = 1'b0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
